alu_op_issue: RTL and testbench
===============================

Name: alu_op_issue

Overview:
- ID/EX-side producer for the ALU's 4-bit `alu_op` interface. It is the encoder matching the ALU's decoder.
- Takes a decoded RV32I instruction plus operand data from ID and generates the ALU op code and both ALU operands.
- Registers these into a one-entry valid/ready pipeline slot with flush, feeding the EX-stage ALU.
- Also flags encodings the ALU cannot execute and counts issued ops.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate
- CNT_W, 16, width of the issued-op counter

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  ID presents an instruction
- in_ready  output  1  slot can accept this cycle
- in_inst  input  32  raw instruction (opcode, funct3, funct7 used)
- in_pc  input  XLEN  instruction PC
- in_rs1_data  input  XLEN  rs1 value (already forwarded)
- in_rs2_data  input  XLEN  rs2 value (already forwarded)
- in_imm  input  XLEN  sign-extended immediate from immgen
- flush  input  1  kill the slot and the current input (branch mispredict)
- out_valid  output  1  slot holds an op for EX
- out_ready  input  1  EX consumes the op this cycle
- out_alu_op  output  4  op code to the ALU
- out_alu_in_1  output  XLEN  ALU operand 1
- out_alu_in_2  output  XLEN  ALU operand 2
- out_store_data  output  XLEN  rs2 value carried for stores
- out_is_branch  output  1  op is a compare (`alu_op[3]` set)
- out_illegal  output  1  encoding the ALU cannot execute
- issue_count  output  CNT_W  number of ops accepted since reset

Behaviour:
- Reset (async, `reset`=1): out_valid=0, out_alu_op=4'b0000, operands/store_data=0, out_is_branch=0, out_illegal=0, issue_count=0.
- Op codes: ADD 0001, SUB 0010, SLL 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, BEQ 1000, BNE 1001, BLT 1010, BGE 1011; NOP 0000.
- R-type (0110011), in_1=rs1, in_2=rs2:
  - f3 000: f7[5]=0 ADD, f7[5]=1 SUB.
  - f3 001 SLL, 100 XOR, 110 OR, 111 AND.
  - f3 101: f7[5]=0 SRL, f7[5]=1 (SRA) illegal.
  - f3 010/011 illegal.
- I-arith (0010011), in_1=rs1, in_2=imm:
  - Same mapping as R-type, but f3 000 is always ADD.
  - f3 101 with inst[30]=1 is illegal.
  - f3 010/011 illegal.
- LOAD (0000011), STORE (0100011): ADD, in_1=rs1, in_2=imm. store_data=rs2 for both.
- BRANCH (1100011), in_1=rs1, in_2=rs2:
  - f3 000 BEQ, 001 BNE, 100 BLT, 101 BGE.
  - 110/111 (unsigned) and 010/011 illegal.
- JAL (1101111), JALR (1100111): ADD, in_1=pc, in_2=4 (link value).
- LUI (0110111): ADD, in_1=0, in_2=imm.
- AUIPC (0010111): ADD, in_1=pc, in_2=imm.
- SYSTEM (1110011): NOP, not illegal.
- Any other opcode: illegal.
- Illegal encodings: alu_op=NOP, in_1/in_2=0.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational; no skid buffer).
  - Accept = in_valid & in_ready & !flush. On accept, the slot loads next edge and out_valid=1. Latency is 1 cycle from accept to out_valid.
  - Consume (out_valid & out_ready) without accept: out_valid drops to 0 next edge.
  - Simultaneous consume and accept: back-to-back reload, out_valid stays 1.
  - Stall (out_valid & !out_ready): slot contents held bit-exact; in_ready=0.
- Flush:
  - Highest priority. Next edge out_valid=0, out_alu_op=NOP, out_is_branch=0, out_illegal=0.
  - The input presented in the same cycle is dropped and not counted.
  - Flush while stalled also empties the slot.
- issue_count:
  - Increments by 1 per accept, illegal ops included.
  - Wraps from 2^CNT_W-1 to 0; no saturation.
- out_is_branch = registered alu_op[3].
- Reset asserted mid-operation clears the slot immediately, without waiting for clk.

Optional Feature:
- Macro: ALU_ISSUE_ILLEGAL_TRAP_EN
- Defined:
  - Illegal encodings still load the slot with out_illegal=1, so EX can raise an exception.
  - A sticky illegal is held until consumed or flushed.
- Undefined:
  - out_illegal is tied 0.
  - Illegal encodings load as plain NOP ops (operands 0) and count normally.

Test Plan:
- Reset sequencing: reset pulse mid-cycle while out_valid=1 -> out_valid=0 and issue_count=0 immediately, without a clk edge.
- R-type decode: accept `add` then `sub` (f7=0100000), out_ready=1 -> alu_op 0001 then 0010, in_1=rs1, in_2=rs2, issue_count=2.
- Operand selection:
  - AUIPC with pc=0x100, imm=0x3000 -> alu_op 0001, in_1=0x100, in_2=0x3000.
  - JAL with pc=0x40 -> in_1=0x40, in_2=4.
- Branch decode: BGE (f3=101), rs1=0xFFFFFFFF, rs2=1 -> alu_op 1011, out_is_branch=1.
  - The ALU downstream must give bcond=0.
- Stall then flush: out_ready=0 for 3 cycles with a new in_valid -> in_ready=0 and slot held.
  - Then flush=1 -> out_valid=0 next cycle, pending input dropped, issue_count unchanged.
- Illegal input: SRA (f3=101, f7[5]=1).
  - With ALU_ISSUE_ILLEGAL_TRAP_EN: out_illegal=1, alu_op=0000.
  - Without it: out_illegal=0, alu_op=0000.
  - issue_count increments in both builds.

Source files
------------

// File: rtl/alu_op_issue.sv
// ID/EX issue slot: encodes RV32I instructions into the ALU op/operand interface and
// holds one op in a valid/ready slot. Define ALU_ISSUE_ILLEGAL_TRAP_EN to flag illegal ops.
module alu_op_issue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_op,
  output logic [XLEN-1:0]  out_alu_in_1,
  output logic [XLEN-1:0]  out_alu_in_2,
  output logic [XLEN-1:0]  out_store_data,
  output logic             out_is_branch,
  output logic             out_illegal,
  output logic [CNT_W-1:0] issue_count
);

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000, OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_SLL = 4'b0011,
    OP_XOR = 4'b0100, OP_SRL = 4'b0101, OP_OR  = 4'b0110, OP_AND = 4'b0111,
    OP_BEQ = 4'b1000, OP_BNE = 4'b1001, OP_BLT = 4'b1010, OP_BGE = 4'b1011
  } alu_op_e;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7b5;
  logic       unused_inst_bits;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7b5   = in_inst[30];
  assign unused_inst_bits = ^{in_inst[31], in_inst[29:15], in_inst[11:7]};

  alu_op_e         dec_op;
  logic [XLEN-1:0] dec_in1, dec_in2, dec_store;
  logic            dec_illegal;

  always_comb begin
    dec_op      = OP_NOP;
    dec_in1     = '0;
    dec_in2     = '0;
    dec_store   = '0;
    dec_illegal = 1'b0;
    unique case (opcode)
      7'b0110011, 7'b0010011: begin
        dec_in1 = in_rs1_data;
        dec_in2 = (opcode == 7'b0110011) ? in_rs2_data : in_imm;
        case (f3)
          3'b000:  dec_op = (opcode == 7'b0110011 && f7b5) ? OP_SUB : OP_ADD;
          3'b001:  dec_op = OP_SLL;
          3'b100:  dec_op = OP_XOR;
          3'b101:  if (f7b5) dec_illegal = 1'b1; else dec_op = OP_SRL;
          3'b110:  dec_op = OP_OR;
          3'b111:  dec_op = OP_AND;
          default: dec_illegal = 1'b1;
        endcase
      end
      7'b0000011, 7'b0100011: begin
        dec_op    = OP_ADD;
        dec_in1   = in_rs1_data;
        dec_in2   = in_imm;
        dec_store = in_rs2_data;
      end
      7'b1100011: begin
        dec_in1 = in_rs1_data;
        dec_in2 = in_rs2_data;
        case (f3)
          3'b000:  dec_op = OP_BEQ;
          3'b001:  dec_op = OP_BNE;
          3'b100:  dec_op = OP_BLT;
          3'b101:  dec_op = OP_BGE;
          default: dec_illegal = 1'b1;
        endcase
      end
      7'b1101111, 7'b1100111: begin
        dec_op  = OP_ADD;
        dec_in1 = in_pc;
        dec_in2 = XLEN'(4);
      end
      7'b0110111: begin
        dec_op  = OP_ADD;
        dec_in2 = in_imm;
      end
      7'b0010111: begin
        dec_op  = OP_ADD;
        dec_in1 = in_pc;
        dec_in2 = in_imm;
      end
      7'b1110011: dec_op = OP_NOP;
      default:    dec_illegal = 1'b1;
    endcase
    // Illegal encodings always issue as a zero-operand NOP.
    if (dec_illegal) begin
      dec_op    = OP_NOP;
      dec_in1   = '0;
      dec_in2   = '0;
      dec_store = '0;
    end
  end

  logic             valid_q, valid_d;
  alu_op_e          op_q, op_d;
  logic [XLEN-1:0]  in1_q, in1_d, in2_q, in2_d, store_q, store_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, consume;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign consume  = valid_q && out_ready;

  always_comb begin
    valid_d   = valid_q;
    op_d      = op_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    store_d   = store_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (flush) begin
      valid_d   = 1'b0;
      op_d      = OP_NOP;
      illegal_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      op_d    = dec_op;
      in1_d   = dec_in1;
      in2_d   = dec_in2;
      store_d = dec_store;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      illegal_d = dec_illegal;
`else
      illegal_d = 1'b0;
`endif
      cnt_d = cnt_q + 1'b1;
    end else if (consume) begin
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      op_q      <= OP_NOP;
      in1_q     <= '0;
      in2_q     <= '0;
      store_q   <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      op_q      <= op_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      store_q   <= store_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_alu_op     = op_q;
  assign out_alu_in_1   = in1_q;
  assign out_alu_in_2   = in2_q;
  assign out_store_data = store_q;
  assign out_is_branch  = op_q[3];
  assign out_illegal    = illegal_q;
  assign issue_count    = cnt_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed-vector bench for alu_op_issue; honours ALU_ISSUE_ILLEGAL_TRAP_EN for out_illegal.
module tb_alu_op_issue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]      in_inst;
  logic [XLEN-1:0]  in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [3:0]       out_alu_op;
  logic [XLEN-1:0]  out_alu_in_1, out_alu_in_2, out_store_data;
  logic             out_is_branch, out_illegal;
  logic [CNT_W-1:0] issue_count;

  alu_op_issue #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .in_imm(in_imm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
    .out_alu_in_1(out_alu_in_1), .out_alu_in_2(out_alu_in_2),
    .out_store_data(out_store_data), .out_is_branch(out_is_branch),
    .out_illegal(out_illegal), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  int unsigned      n_cmp = 0;
  int unsigned      n_err = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [6:0] opc);
    return {f7, 10'd0, f3, 5'd0, opc};
  endfunction

  // Presents one instruction for exactly one clock edge; returns 1ns after that edge.
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic counts);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    in_rs1_data = rs1; in_rs2_data = rs2; in_imm = imm;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (counts) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic slot(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic ill);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".op"}, 64'(out_alu_op), 64'(op));
    check({tag, ".in1"}, 64'(out_alu_in_1), 64'(a));
    check({tag, ".in2"}, 64'(out_alu_in_2), 64'(b));
    check({tag, ".br"}, 64'(out_is_branch), 64'(op[3]));
    check({tag, ".ill"}, 64'(out_illegal), 64'(ill));
    check({tag, ".cnt"}, 64'(issue_count), 64'(exp_cnt));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_inst = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.op", 64'(out_alu_op), 64'd0);
    check("rst.in1", 64'(out_alu_in_1), 64'd0);
    check("rst.ill", 64'(out_illegal), 64'd0);
    check("rst.cnt", 64'(issue_count), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Back-to-back decode with the ALU always ready.
    issue(mk(7'h00, 3'b000, 7'b0110011), 0, 32'd5, 32'd7, 0, 1'b1);
    slot("add", 4'b0001, 32'd5, 32'd7, 1'b0);
    issue(mk(7'h20, 3'b000, 7'b0110011), 0, 32'd9, 32'd3, 0, 1'b1);
    slot("sub", 4'b0010, 32'd9, 32'd3, 1'b0);
    issue(mk(7'h00, 3'b001, 7'b0110011), 0, 32'd1, 32'd4, 0, 1'b1);
    slot("sll", 4'b0011, 32'd1, 32'd4, 1'b0);
    issue(mk(7'h00, 3'b110, 7'b0110011), 0, 32'hF0, 32'h0F, 0, 1'b1);
    slot("or", 4'b0110, 32'hF0, 32'h0F, 1'b0);
    issue(mk(7'h20, 3'b000, 7'b0010011), 0, 32'd8, 0, 32'hFFFFFFFF, 1'b1);
    slot("addi_f7", 4'b0001, 32'd8, 32'hFFFFFFFF, 1'b0);
    issue(mk(7'h00, 3'b111, 7'b0010011), 0, 32'hAA, 0, 32'h0F, 1'b1);
    slot("andi", 4'b0111, 32'hAA, 32'h0F, 1'b0);
    issue(mk(7'h00, 3'b100, 7'b0010011), 0, 32'h3, 0, 32'h5, 1'b1);
    slot("xori", 4'b0100, 32'h3, 32'h5, 1'b0);
    issue(mk(7'h00, 3'b101, 7'b0010011), 0, 32'h80, 0, 32'd2, 1'b1);
    slot("srli", 4'b0101, 32'h80, 32'd2, 1'b0);
    issue(mk(7'h00, 3'b000, 7'b0010111), 32'h100, 32'h55, 32'h66, 32'h3000, 1'b1);
    slot("auipc", 4'b0001, 32'h100, 32'h3000, 1'b0);
    issue(mk(7'h00, 3'b000, 7'b1101111), 32'h40, 32'h55, 32'h66, 32'h800, 1'b1);
    slot("jal", 4'b0001, 32'h40, 32'd4, 1'b0);
    issue(mk(7'h00, 3'b000, 7'b0110111), 32'h40, 32'h55, 32'h66, 32'h12345000, 1'b1);
    slot("lui", 4'b0001, 32'd0, 32'h12345000, 1'b0);
    issue(mk(7'h00, 3'b010, 7'b0100011), 0, 32'h1000, 32'hDEAD, 32'h10, 1'b1);
    slot("sw", 4'b0001, 32'h1000, 32'h10, 1'b0);
    check("sw.sdata", 64'(out_store_data), 64'hDEAD);
    issue(mk(7'h00, 3'b101, 7'b1100011), 0, 32'hFFFFFFFF, 32'd1, 32'h20, 1'b1);
    slot("bge", 4'b1011, 32'hFFFFFFFF, 32'd1, 1'b0);
    issue(mk(7'h00, 3'b001, 7'b1100011), 0, 32'd2, 32'd3, 32'h20, 1'b1);
    slot("bne", 4'b1001, 32'd2, 32'd3, 1'b0);
    issue(mk(7'h00, 3'b000, 7'b1110011), 0, 32'd2, 32'd3, 32'h20, 1'b1);
    slot("system", 4'b0000, 32'd0, 32'd0, 1'b0);

    // Illegal encodings: zeroed NOP, still counted.
    issue(mk(7'h20, 3'b101, 7'b0110011), 0, 32'h11, 32'h22, 0, 1'b1);
    slot("sra", 4'b0000, 32'd0, 32'd0, EXP_ILL);
    issue(mk(7'h00, 3'b110, 7'b1100011), 0, 32'h11, 32'h22, 0, 1'b1);
    slot("bltu", 4'b0000, 32'd0, 32'd0, EXP_ILL);
    issue(mk(7'h00, 3'b000, 7'b1111111), 32'h4, 32'h11, 32'h22, 32'h9, 1'b1);
    out_ready = 1'b0;
    slot("badopc", 4'b0000, 32'd0, 32'd0, EXP_ILL);
    @(posedge clk); #1;
    check("ill_hold.ill", 64'(out_illegal), 64'(EXP_ILL));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("consume.valid", 64'(out_valid), 64'd0);
    check("consume.ill", 64'(out_illegal), 64'd0);

    // Stall with a pending input, then flush.
    out_ready = 1'b0;
    issue(mk(7'h00, 3'b000, 7'b0110011), 0, 32'hA, 32'hB, 0, 1'b1);
    slot("stall_ld", 4'b0001, 32'hA, 32'hB, 1'b0);
    in_valid = 1'b1; in_inst = mk(7'h20, 3'b000, 7'b0110011);
    in_rs1_data = 32'h77; in_rs2_data = 32'h88;
    check("stall.in_ready", 64'(in_ready), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      slot("stall", 4'b0001, 32'hA, 32'hB, 1'b0);
      check("stall.in_ready", 64'(in_ready), 64'd0);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush.valid", 64'(out_valid), 64'd0);
    check("flush.op", 64'(out_alu_op), 64'd0);
    check("flush.br", 64'(out_is_branch), 64'd0);
    check("flush.cnt", 64'(issue_count), 64'(exp_cnt));
    out_ready = 1'b1;

    // Flush coinciding with an input into an empty slot drops it.
    flush = 1'b1;
    issue(mk(7'h00, 3'b000, 7'b1100011), 0, 32'd1, 32'd1, 0, 1'b0);
    flush = 1'b0;
    check("flush_in.valid", 64'(out_valid), 64'd0);
    check("flush_in.cnt", 64'(issue_count), 64'(exp_cnt));

    // Counter wrap.
    for (int i = 0; i < 16 && exp_cnt != 4'hF; i++)
      issue(mk(7'h00, 3'b000, 7'b0110011), 0, 32'd1, 32'd1, 0, 1'b1);
    check("wrap.pre", 64'(issue_count), 64'hF);
    issue(mk(7'h00, 3'b100, 7'b0110011), 0, 32'd6, 32'd3, 0, 1'b1);
    check("wrap.zero", 64'(issue_count), 64'd0);
    slot("wrap", 4'b0100, 32'd6, 32'd3, 1'b0);

    // Asynchronous reset between clock edges while the slot is full.
    out_ready = 1'b0;
    issue(mk(7'h00, 3'b000, 7'b0110011), 0, 32'd2, 32'd2, 0, 1'b1);
    check("pre_areset.valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("areset.valid", 64'(out_valid), 64'd0);
    check("areset.cnt", 64'(issue_count), 64'd0);
    check("areset.op", 64'(out_alu_op), 64'd0);
    exp_cnt = '0;
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
